// File: rtl/uartm_cmd_seq.sv
// UART-to-Wishbone command sequencer: parses 0x57 (write) / 0x52 (read) frames and runs one single bus cycle per frame.
// Optional bus watchdog enabled by defining UARTM_BUS_TMO_EN.
module uartm_cmd_seq #(
  parameter logic [15:0] IBYTE_TMO = 16'd4096,
  parameter logic [15:0] BUS_TMO   = 16'd1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  // Handshakes: a byte moves on rx/tx only in a cycle where valid and ready are both high;
  // tx_data/tx_valid never change while tx_valid is high and tx_ready is low.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_WDATA     = 3'd2,
    S_BUS       = 3'd3,
    S_RESP_HDR  = 3'd4,
    S_RESP_DATA = 3'd5
  } state_t;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ST_OK  = 8'hAA;
  localparam logic [7:0] ST_ERR = 8'hEE;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic        we_r, we_n;
  logic [7:0]  status, status_n;
  logic [31:0] rdata, rdata_n;
  logic [31:0] adr, adr_n;
  logic [31:0] dat, dat_n;
  logic [15:0] ibyte_tmr, ibyte_tmr_n;
  logic        err_inc;
  logic        rx_fire;

`ifdef UARTM_BUS_TMO_EN
  logic [15:0] bus_tmr, bus_tmr_n;
`else
  logic        unused_bus_tmo;
  assign unused_bus_tmo = ^BUS_TMO;
`endif

  // rx_ready is forced low while reset is held so every output reads 0 in reset.
  assign rx_ready = ~wb_rst_i & ((state == S_IDLE) | (state == S_ADDR) | (state == S_WDATA));
  assign rx_fire  = rx_valid & rx_ready;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    we_n        = we_r;
    status_n    = status;
    rdata_n     = rdata;
    adr_n       = adr;
    dat_n       = dat;
    ibyte_tmr_n = '0;
    err_inc     = 1'b0;
`ifdef UARTM_BUS_TMO_EN
    bus_tmr_n   = '0;
`endif
    unique case (state)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            we_n    = (rx_data == CMD_WR);
            cnt_n   = '0;
            state_n = S_ADDR;
          end else begin
            status_n = ST_ERR;
            err_inc  = 1'b1;
            state_n  = S_RESP_HDR;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          adr_n = {adr[23:0], rx_data};
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) state_n = we_r ? S_WDATA : S_BUS;
        end else if (ibyte_tmr == IBYTE_TMO - 16'd1) begin
          state_n = S_IDLE;
          err_inc = 1'b1;
        end else begin
          ibyte_tmr_n = ibyte_tmr + 16'd1;
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          dat_n = {dat[23:0], rx_data};
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) state_n = S_BUS;
        end else if (ibyte_tmr == IBYTE_TMO - 16'd1) begin
          state_n = S_IDLE;
          err_inc = 1'b1;
        end else begin
          ibyte_tmr_n = ibyte_tmr + 16'd1;
        end
      end
      S_BUS: begin
        // err has priority when the slave raises ack and err together
        if (wbm_err_i) begin
          status_n = ST_ERR;
          err_inc  = 1'b1;
          state_n  = S_RESP_HDR;
        end else if (wbm_ack_i) begin
          status_n = ST_OK;
          if (!we_r) rdata_n = wbm_dat_i;
          state_n  = S_RESP_HDR;
        end
`ifdef UARTM_BUS_TMO_EN
        else if (bus_tmr == BUS_TMO - 16'd1) begin
          status_n = ST_ERR;
          err_inc  = 1'b1;
          state_n  = S_RESP_HDR;
        end else begin
          bus_tmr_n = bus_tmr + 16'd1;
        end
`endif
      end
      S_RESP_HDR: begin
        if (tx_ready) begin
          if (status == ST_OK && !we_r) begin
            cnt_n   = '0;
            state_n = S_RESP_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_RESP_DATA: begin
        if (tx_ready) begin
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_r      <= 1'b0;
      status    <= '0;
      rdata     <= '0;
      adr       <= '0;
      dat       <= '0;
      ibyte_tmr <= '0;
      err_cnt   <= '0;
`ifdef UARTM_BUS_TMO_EN
      bus_tmr   <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      we_r      <= we_n;
      status    <= status_n;
      rdata     <= rdata_n;
      adr       <= adr_n;
      dat       <= dat_n;
      ibyte_tmr <= ibyte_tmr_n;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef UARTM_BUS_TMO_EN
      bus_tmr   <= bus_tmr_n;
`endif
    end
  end

  assign busy      = (state != S_IDLE);
  assign wbm_cyc_o = (state == S_BUS);
  assign wbm_stb_o = (state == S_BUS);
  assign wbm_we_o  = (state == S_BUS) & we_r;
  assign wbm_sel_o = (state == S_BUS) ? 4'hF : 4'h0;
  assign wbm_adr_o = adr;
  assign wbm_dat_o = dat;
  assign tx_valid  = (state == S_RESP_HDR) | (state == S_RESP_DATA);

  always_comb begin
    tx_data = '0;
    if (state == S_RESP_HDR) begin
      tx_data = status;
    end else if (state == S_RESP_DATA) begin
      unique case (cnt)
        2'd0:    tx_data = rdata[31:24];
        2'd1:    tx_data = rdata[23:16];
        2'd2:    tx_data = rdata[15:8];
        default: tx_data = rdata[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_uartm_cmd_seq.sv
// Scoreboard bench for uartm_cmd_seq: frames are issued by driver tasks, expected tx bytes and bus cycles
// are queued by a frame-level model, and independent monitors compare what the DUT presents.
module tb_uartm_cmd_seq;

  localparam logic [15:0] IBYTE_TMO = 16'd64;
  localparam logic [15:0] BUS_TMO   = 16'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;

  uartm_cmd_seq #(.IBYTE_TMO(IBYTE_TMO), .BUS_TMO(BUS_TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy(busy), .err_cnt(err_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_tx_q[$];
  logic [65:0] exp_bus_q[$];   // {check_dat, we, adr, dat}
  logic [7:0]  model_err = '0;
  int          tx_mode = 0;    // 0: always ready, 1: random, 2: hold 5 cycles per byte
  int          slv_delay = 0;
  bit          slv_err = 1'b0;
  bit          slv_silent = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected no such event", name, act);
  endtask

  task automatic model_err_inc();
    if (model_err != 8'hFF) model_err = model_err + 8'd1;
  endtask

  // tx_ready driver
  int hold_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (tx_valid) begin
          if (hold_cnt == 5) begin
            tx_ready = 1'b1;
            hold_cnt = 0;
          end else begin
            tx_ready = 1'b0;
            hold_cnt++;
          end
        end else begin
          tx_ready = 1'b0;
          hold_cnt = 0;
        end
      end
    endcase
  end

  // Wishbone slave
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wcnt = 0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
      if (!slv_silent) begin
        if (wcnt >= slv_delay) begin
          wbm_ack_i = 1'b1;
          wbm_err_i = slv_err;
        end else begin
          wcnt++;
        end
      end
    end else begin
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wcnt = 0;
    end
  end

  // tx monitor: byte order and stability while stalled
  logic       prev_pend = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) fail("tx_unexpected", tx_data);
        else chk("tx_byte", tx_data, exp_tx_q.pop_front());
        prev_pend = 1'b0;
      end else begin
        prev_pend = tx_valid;
        prev_data = tx_data;
      end
    end
  end

  // bus monitor: completed cycles and ack-to-status latency
  logic        ack_seen = 1'b0;
  logic [65:0] bus_e;
  always @(negedge clk) begin
    if (rst) begin
      ack_seen = 1'b0;
    end else begin
      if (ack_seen) begin
        chk("ack_to_tx_valid", tx_valid, 1);
        chk("ack_cyc_drop", wbm_cyc_o, 0);
        ack_seen = 1'b0;
      end
      if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
        if (exp_bus_q.size() == 0) begin
          fail("bus_unexpected", wbm_adr_o);
        end else begin
          bus_e = exp_bus_q.pop_front();
          chk("bus_we", wbm_we_o, bus_e[64]);
          chk("bus_adr", wbm_adr_o, bus_e[63:32]);
          if (bus_e[65]) chk("bus_dat", wbm_dat_o, bus_e[31:0]);
          chk("bus_sel", wbm_sel_o, 4'hF);
        end
        ack_seen = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) fail("rx_accept_timeout", b);
    else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_tx_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy || exp_tx_q.size() != 0) fail({name, "_idle_timeout"}, n);
    chk({name, "_err_cnt"}, err_cnt, model_err);
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                          input int dly, input bit er, input int gaps);
    logic [7:0] bytes[$];
    slv_delay  = dly;
    slv_err    = er;
    slv_silent = 1'b0;
    if (!is_wr) wbm_dat_i = d;
    exp_bus_q.push_back({is_wr, is_wr, a, d});
    if (er) begin
      exp_tx_q.push_back(8'hEE);
      model_err_inc();
    end else begin
      exp_tx_q.push_back(8'hAA);
      if (!is_wr) for (int i = 3; i >= 0; i--) exp_tx_q.push_back(d[8*i +: 8]);
    end
    bytes.push_back(is_wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) bytes.push_back(a[8*i +: 8]);
    if (is_wr) for (int i = 3; i >= 0; i--) bytes.push_back(d[8*i +: 8]);
    foreach (bytes[i]) begin
      if (gaps > 0 && i > 0) gap($urandom_range(0, gaps));
      send_byte(bytes[i]);
    end
    chk("cyc_latency", wbm_cyc_o, 1);
    wait_idle(is_wr ? "wr" : "rd");
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_tx_q.push_back(8'hEE);
    model_err_inc();
    send_byte(b);
    wait_idle("bad_hdr");
  endtask

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
    return b;
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_sel", wbm_sel_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rx_ready", rx_ready, 1);

    tx_mode = 0;
    do_frame(1'b1, 32'h3002_0058, 32'h1122_3344, 3, 1'b0, 0);
    tx_mode = 2;
    do_frame(1'b0, 32'h3002_0058, 32'h1122_3344, 1, 1'b0, 0);
    tx_mode = 0;
    do_bad(8'h41);
    do_frame(1'b1, 32'h3080_0000, 32'h0000_0001, 0, 1'b0, 0);

    // inter-byte timeout: abort with no response byte
    send_byte(8'h57);
    send_byte(8'h30);
    send_byte(8'h02);
    repeat (int'(IBYTE_TMO) - 4) @(negedge clk);
    chk("ibyte_tmo_still_busy", busy, 1);
    model_err_inc();
    repeat (8) @(negedge clk);
    chk("ibyte_tmo_idle", busy, 0);
    chk("ibyte_tmo_err_cnt", err_cnt, model_err);
    @(posedge clk);
    #1;

    do_frame(1'b0, 32'h3002_0058, 32'hCAFE_F00D, 2, 1'b1, 0);

`ifdef UARTM_BUS_TMO_EN
    begin
      int n = 0;
      slv_silent = 1'b1;
      exp_tx_q.push_back(8'hEE);
      model_err_inc();
      send_byte(8'h52);
      send_byte(8'h30); send_byte(8'h02); send_byte(8'h00); send_byte(8'h58);
      @(negedge clk);
      while (wbm_cyc_o && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("bus_tmo_cycles", n, BUS_TMO);
      slv_silent = 1'b0;
      wait_idle("bus_tmo");
    end
`endif

    tx_mode = 1;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 7) == 0) do_bad(rand_bad());
      else do_frame(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 4),
                    ($urandom_range(0, 5) == 0), 2);
    end

    tx_mode = 0;
    for (int k = 0; k < 256; k++) do_bad(rand_bad());
    chk("err_cnt_saturated", err_cnt, 8'hFF);

    // reset in the middle of the write data bytes
    send_byte(8'h57);
    send_byte(8'h30); send_byte(8'h80); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'hA5); send_byte(8'h5A);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cyc", wbm_cyc_o, 0);
    chk("mid_rst_adr", wbm_adr_o, 0);
    chk("mid_rst_dat", wbm_dat_o, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    model_err = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_frame(1'b1, 32'h3080_0000, 32'h0000_0001, 1, 1'b0, 0);

    chk("tx_q_drained", exp_tx_q.size(), 0);
    chk("bus_q_drained", exp_bus_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
